// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode stage.
// - Field widths: opcode (OPW) and register index (RW).
// - Jump opcode constants.
// - Bit position of the IMM flag in an opcode word.
// - The FSM state encoding.
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam int OPW = 5;
    localparam int RW  = 3;

    localparam logic [4:0] OP_JZ  = 5'b11100;
    localparam logic [4:0] OP_JN  = 5'b11101;
    localparam logic [4:0] OP_JC  = 5'b11110;
    localparam logic [4:0] OP_JMP = 5'b11111;

    localparam int IMM_BIT = 0;

    // 2'd3 is never entered; the next-state logic sends it back to S_OP.
    typedef enum logic [1:0] {
        S_OP    = 2'd0,
        S_IMM   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/decode_stage_jump_resolver.sv
// ---------------------------------------------------------------------------
// jump_resolver
// Combinational jump classification for the decode stage.
//
// Ports:
//   i_opcode  - opcode field of the word on Instr
//   i_zf      - zero flag
//   i_nf      - negative flag
//   i_cf      - carry flag
//   o_is_jump - opcode is one of JZ/JN/JC/JMP
//   o_taken   - the jump redirects (JMP always, Jx on its flag)
// ---------------------------------------------------------------------------
import decode_pkg::*;

module jump_resolver #(
    parameter int OPW = decode_pkg::OPW
) (
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_zf,
    input  logic           i_nf,
    input  logic           i_cf,
    output logic           o_is_jump,
    output logic           o_taken
);

    always_comb begin
        o_is_jump = 1'b0;
        o_taken   = 1'b0;
        case (i_opcode)
            OP_JZ:  begin o_is_jump = 1'b1; o_taken = i_zf; end
            OP_JN:  begin o_is_jump = 1'b1; o_taken = i_nf; end
            OP_JC:  begin o_is_jump = 1'b1; o_taken = i_cf; end
            OP_JMP: begin o_is_jump = 1'b1; o_taken = 1'b1; end
            default: begin
                o_is_jump = 1'b0;
                o_taken   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Consumer end of the instruction-fetch stream.
// - Assembles one- and two-word instructions into decoded fields.
// - Resolves jumps and drives the redirect pulse and target back to fetch.
// - Discards the single wrong-path word that follows a taken jump.
//
// Ports:
//   Clk       - rising-edge clock
//   Rst       - synchronous active-high reset
//   Instr     - 16-bit word from fetch
//   Stall     - hazard hold; freezes the block for the cycle
//   RdstData  - register value of Instr's Rdst field (the jump target)
//   Zf/Nf/Cf  - condition flags, sampled with the jump word
//   Valid     - decoded fields form a complete instruction
//   Opcode    - opcode field
//   Rsrc      - source register field
//   Rdst      - destination register field
//   Imm       - immediate word (0 for single-word instructions)
//   JmpTaken  - one-cycle redirect pulse
//   JmpTarget - redirect PC, meaningful while JmpTaken=1
//   DbgState  - current FSM state, for observation only
//
// Handshake: there is no backpressure toward fetch. Valid is a one-cycle
// qualifier; whenever Valid=1 the register-read stage must take Opcode,
// Rsrc, Rdst and Imm that cycle. Stall only freezes this block.
// All outputs are registered.
// ---------------------------------------------------------------------------
import decode_pkg::*;

module decode_stage #(
    parameter int OPW = decode_pkg::OPW,
    parameter int RW  = decode_pkg::RW
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [15:0]    Instr,
    input  logic           Stall,
    input  logic [31:0]    RdstData,
    input  logic           Zf,
    input  logic           Nf,
    input  logic           Cf,
    output logic           Valid,
    output logic [OPW-1:0] Opcode,
    output logic [RW-1:0]  Rsrc,
    output logic [RW-1:0]  Rdst,
    output logic [15:0]    Imm,
    output logic           JmpTaken,
    output logic [31:0]    JmpTarget,
    output logic [1:0]     DbgState
);

    state_t         r_state;
    logic           r_valid;
    logic [OPW-1:0] r_opcode;
    logic [RW-1:0]  r_rsrc;
    logic [RW-1:0]  r_rdst;
    logic [15:0]    r_imm;
    logic           r_jmp_taken;
    logic [31:0]    r_jmp_target;

    state_t         w_state_nxt;
    logic           w_valid_nxt;
    logic [OPW-1:0] w_opcode_nxt;
    logic [RW-1:0]  w_rsrc_nxt;
    logic [RW-1:0]  w_rdst_nxt;
    logic [15:0]    w_imm_nxt;
    logic           w_jmp_taken_nxt;
    logic [31:0]    w_jmp_target_nxt;

    logic [OPW-1:0] w_in_opcode;
    logic [RW-1:0]  w_in_rsrc;
    logic [RW-1:0]  w_in_rdst;
    logic           w_in_imm_flag;
    logic           w_is_jump;
    logic           w_taken;

    assign w_in_opcode   = Instr[15:11];
    assign w_in_rsrc     = Instr[10:8];
    assign w_in_rdst     = Instr[7:5];
    assign w_in_imm_flag = Instr[IMM_BIT];

    jump_resolver #(
        .OPW (OPW)
    ) u_jump_resolver (
        .i_opcode  (w_in_opcode),
        .i_zf      (Zf),
        .i_nf      (Nf),
        .i_cf      (Cf),
        .o_is_jump (w_is_jump),
        .o_taken   (w_taken)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_OP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next output values
    always_comb begin
        w_state_nxt      = r_state;
        w_valid_nxt      = 1'b0;
        w_jmp_taken_nxt  = 1'b0;
        w_opcode_nxt     = r_opcode;
        w_rsrc_nxt       = r_rsrc;
        w_rdst_nxt       = r_rdst;
        w_imm_nxt        = r_imm;
        w_jmp_target_nxt = r_jmp_target;

        // Stall freezes state and fields; pulses drop to 0 by the defaults.
        if (!Stall) begin
            case (r_state)
                S_OP: begin
                    w_opcode_nxt = w_in_opcode;
                    w_rsrc_nxt   = w_in_rsrc;
                    w_rdst_nxt   = w_in_rdst;
                    if (w_is_jump) begin
                        // Jumps are single-word whatever their IMM bit says.
                        w_imm_nxt   = 16'h0000;
                        w_valid_nxt = 1'b1;
                        if (w_taken) begin
                            w_jmp_taken_nxt  = 1'b1;
                            w_jmp_target_nxt = RdstData;
                            w_state_nxt      = S_FLUSH;
                        end
                    end else if (w_in_imm_flag) begin
                        w_state_nxt = S_IMM;
                    end else begin
                        w_imm_nxt   = 16'h0000;
                        w_valid_nxt = 1'b1;
                    end
                end
                S_IMM: begin
                    // Raw data word: never decoded, even if it looks like a jump.
                    w_imm_nxt   = Instr;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_OP;
                end
                S_FLUSH: begin
                    w_state_nxt = S_OP;
                end
                default: begin
                    w_state_nxt = S_OP;
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_valid      <= 1'b0;
            r_opcode     <= '0;
            r_rsrc       <= '0;
            r_rdst       <= '0;
            r_imm        <= 16'h0000;
            r_jmp_taken  <= 1'b0;
            r_jmp_target <= 32'h0000_0000;
        end else begin
            r_valid      <= w_valid_nxt;
            r_opcode     <= w_opcode_nxt;
            r_rsrc       <= w_rsrc_nxt;
            r_rdst       <= w_rdst_nxt;
            r_imm        <= w_imm_nxt;
            r_jmp_taken  <= w_jmp_taken_nxt;
            r_jmp_target <= w_jmp_target_nxt;
        end
    end

    assign Valid     = r_valid;
    assign Opcode    = r_opcode;
    assign Rsrc      = r_rsrc;
    assign Rdst      = r_rdst;
    assign Imm       = r_imm;
    assign JmpTaken  = r_jmp_taken;
    assign JmpTarget = r_jmp_target;
    assign DbgState  = r_state;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        stall;
  logic [31:0] rdst_data;
  logic        zf, nf, cf;
  logic        valid;
  logic [4:0]  opcode;
  logic [2:0]  rsrc;
  logic [2:0]  rdst;
  logic [15:0] imm;
  logic        jmp_taken;
  logic [31:0] jmp_target;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] ST_OP    = 2'd0;
  localparam logic [1:0] ST_IMM   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  decode_stage dut (
    .Clk       (clk),
    .Rst       (rst),
    .Instr     (instr),
    .Stall     (stall),
    .RdstData  (rdst_data),
    .Zf        (zf),
    .Nf        (nf),
    .Cf        (cf),
    .Valid     (valid),
    .Opcode    (opcode),
    .Rsrc      (rsrc),
    .Rdst      (rdst),
    .Imm       (imm),
    .JmpTaken  (jmp_taken),
    .JmpTarget (jmp_target),
    .DbgState  (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive a word with all other inputs quiet, then clock it in
  task automatic drive(input logic [15:0] w);
    instr = w;
    step();
  endtask

  task automatic check_fields(input string tag, input logic v, input logic [4:0] op,
                              input logic [2:0] rs, input logic [2:0] rd,
                              input logic [15:0] im, input logic jt, input logic [1:0] st);
    check({tag, ".valid"},  {31'd0, valid},     {31'd0, v});
    check({tag, ".opcode"}, {27'd0, opcode},    {27'd0, op});
    check({tag, ".rsrc"},   {29'd0, rsrc},      {29'd0, rs});
    check({tag, ".rdst"},   {29'd0, rdst},      {29'd0, rd});
    check({tag, ".imm"},    {16'd0, imm},       {16'd0, im});
    check({tag, ".jmp"},    {31'd0, jmp_taken}, {31'd0, jt});
    check({tag, ".state"},  {30'd0, dbg_state}, {30'd0, st});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; instr = 16'h0000;
    rdst_data = 32'h0; zf = 1'b0; nf = 1'b0; cf = 1'b0;
    step();
    step();
    check_fields("reset", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, ST_OP);
    check("reset.target", jmp_target, 32'h0);
    rst = 1'b0;

    // reset mid-immediate
    drive(16'h6001);
    check_fields("midimm.op", 1'b0, 5'd12, 3'd0, 3'd0, 16'h0, 1'b0, ST_IMM);
    rst = 1'b1;
    drive(16'hABCD);
    rst = 1'b0;
    check_fields("midimm.rst", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, ST_OP);
    drive(16'h0000);
    check_fields("midimm.next", 1'b1, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, ST_OP);

    // two-word instruction
    drive(16'hC021);
    check("two.t1.valid", {31'd0, valid}, 32'd0);
    check("two.t1.state", {30'd0, dbg_state}, {30'd0, ST_IMM});
    drive(16'hBEEF);
    check_fields("two.t2", 1'b1, 5'b11000, 3'd0, 3'd1, 16'hBEEF, 1'b0, ST_OP);

    // taken JZ
    zf = 1'b1; rdst_data = 32'h0000_0100;
    drive(16'hE020);
    zf = 1'b0; rdst_data = 32'h0;
    check_fields("jz.t1", 1'b1, 5'b11100, 3'd0, 3'd1, 16'h0, 1'b1, ST_FLUSH);
    check("jz.t1.target", jmp_target, 32'h0000_0100);
    drive(16'h0841);  // wrong-path word with IMM set: must be dropped
    check("jz.t2.valid", {31'd0, valid}, 32'd0);
    check("jz.t2.jmp", {31'd0, jmp_taken}, 32'd0);
    check("jz.t2.state", {30'd0, dbg_state}, {30'd0, ST_OP});
    drive(16'h1840);
    check_fields("jz.t3", 1'b1, 5'd3, 3'd0, 3'd2, 16'h0, 1'b0, ST_OP);

    // untaken JC with other flags set
    zf = 1'b1; nf = 1'b1; cf = 1'b0; rdst_data = 32'h1234_5678;
    drive(16'hF060);
    zf = 1'b0; nf = 1'b0; rdst_data = 32'h0;
    check_fields("jc.nt", 1'b1, 5'b11110, 3'd0, 3'd3, 16'h0, 1'b0, ST_OP);
    drive(16'h2000);
    check_fields("jc.next", 1'b1, 5'd4, 3'd0, 3'd0, 16'h0, 1'b0, ST_OP);

    // stall for two cycles in S_IMM
    drive(16'h3121);
    check_fields("stall.op", 1'b0, 5'd6, 3'd1, 3'd1, 16'h0, 1'b0, ST_IMM);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(16'h1234);
      check_fields($sformatf("stall.hold%0d", i), 1'b0, 5'd6, 3'd1, 3'd1, 16'h0, 1'b0, ST_IMM);
    end
    stall = 1'b0;
    drive(16'h1234);
    check_fields("stall.imm", 1'b1, 5'd6, 3'd1, 3'd1, 16'h1234, 1'b0, ST_OP);

    // immediate that looks like JMP
    drive(16'h0801);
    drive(16'hF801);
    check_fields("immjmp", 1'b1, 5'd1, 3'd0, 3'd0, 16'hF801, 1'b0, ST_OP);

    // taken JMP with a stall during the flush cycle
    rdst_data = 32'hDEAD_BEEF;
    drive(16'hF8E0);
    rdst_data = 32'h0;
    check_fields("jmp.t1", 1'b1, 5'b11111, 3'd0, 3'd7, 16'h0, 1'b1, ST_FLUSH);
    check("jmp.t1.target", jmp_target, 32'hDEAD_BEEF);
    stall = 1'b1;
    drive(16'h0800);
    stall = 1'b0;
    check_fields("jmp.stall", 1'b0, 5'b11111, 3'd0, 3'd7, 16'h0, 1'b0, ST_FLUSH);
    drive(16'h0800);
    check("jmp.flush.valid", {31'd0, valid}, 32'd0);
    check("jmp.flush.state", {30'd0, dbg_state}, {30'd0, ST_OP});
    drive(16'h0820);
    check_fields("jmp.target", 1'b1, 5'd1, 3'd0, 3'd1, 16'h0, 1'b0, ST_OP);

    // taken JN, then untaken JZ
    nf = 1'b1; rdst_data = 32'h0000_4000;
    drive(16'hE900);
    nf = 1'b0; rdst_data = 32'h0;
    check_fields("jn.t1", 1'b1, 5'b11101, 3'd1, 3'd0, 16'h0, 1'b1, ST_FLUSH);
    check("jn.t1.target", jmp_target, 32'h0000_4000);
    drive(16'h0000);
    check("jn.flush.valid", {31'd0, valid}, 32'd0);
    drive(16'hE001);  // JZ with IMM bit set, Zf=0: single-word, not taken
    check_fields("jz.nt", 1'b1, 5'b11100, 3'd0, 3'd0, 16'h0, 1'b0, ST_OP);

    // reset takes priority over stall
    drive(16'h5001);
    stall = 1'b1; rst = 1'b1;
    drive(16'h0000);
    stall = 1'b0; rst = 1'b0;
    check_fields("rst.stall", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, ST_OP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Consumer end of the instruction-fetch interface. It takes the 16-bit instruction word that fetch presents every cycle and assembles one- and two-word instructions into decoded fields for the register-read stage. It resolves jumps and drives the 32-bit redirect target and select back into fetch's PC input. It also discards the one wrong-path word fetched before a redirect takes effect.

## Interface
Parameters:
- OPW, 5, opcode field width (Instr[15:11])
- RW, 3, register-index width

Ports:
- Clk  in  1  rising-edge clock; the only clock
- Rst  in  1  reset; synchronous, active-high
- Instr  in  16  word from fetch for the current PC
- Stall  in  1  hazard hold; freezes the block for the cycle
- RdstData  in  32  register-file value of the Rdst field currently on Instr; this is the jump target
- Zf, Nf, Cf  in  1 each  condition flags, sampled with the jump word
- Valid  out  1  decoded fields below are a complete instruction
- Opcode  out  5  Instr[15:11] of the opcode word
- Rsrc  out  3  Instr[10:8]
- Rdst  out  3  Instr[7:5]
- Imm  out  16  second word; 0 for single-word instructions
- JmpTaken  out  1  one-cycle redirect pulse to fetch's PC mux select
- JmpTarget  out  32  new PC; meaningful only while JmpTaken=1

## Operation
- Instruction word format:
  - opcode [15:11], Rsrc [10:8], Rdst [7:5], spare [4:1], IMM flag [0].
  - IMM=1 means the next word is a 16-bit immediate.
- Jump opcodes:
  - JZ 5'b11100, JN 5'b11101, JC 5'b11110, JMP 5'b11111.
  - Jumps are always single-word; their IMM bit is ignored.
- Taken condition: JMP always; JZ if Zf; JN if Nf; JC if Cf.
- States:
  - S_OP: Instr is an opcode word.
  - S_IMM: Instr is the immediate of a held opcode word.
  - S_FLUSH: Instr is a wrong-path word and is discarded.
- S_OP behaviour:
  - Non-jump with IMM=0: load fields, Imm←0, Valid←1, stay in S_OP.
  - Non-jump with IMM=1: latch fields, Valid←0, go to S_IMM.
  - Jump, not taken: load fields, Valid←1, stay in S_OP.
  - Jump, taken: load fields, Valid←1, JmpTaken←1, JmpTarget←RdstData, go to S_FLUSH.
- S_IMM: Imm←Instr, Valid←1, go to S_OP. The word is never decoded, even if its top bits match a jump opcode.
- S_FLUSH: Valid←0, JmpTaken←0, go to S_OP.
- Stall=1 overrides everything:
  - No state change; Opcode, Rsrc, Rdst and Imm hold.
  - Valid←0 and JmpTaken←0 for that cycle.
  - A stall in S_FLUSH delays the flush. The first non-stalled word is still the one discarded; fetch also stalls, so the PC does not move.
- Every output is registered; none depends combinationally on an input.

## Timing
- Reset (Rst=1 at an edge):
  - State→S_OP.
  - Valid, JmpTaken, Opcode, Rsrc, Rdst, Imm and JmpTarget all →0.
  - Takes priority over Stall and over any state, including mid two-word instruction (the latched opcode is dropped).
- Latency:
  - Single-word instruction presented in cycle t → Valid=1 in t+1.
  - Two-word instruction with words in t and t+1 → Valid=1 in t+2; Valid=0 in t+1.
- Redirect:
  - Taken jump presented in t → JmpTaken=1 in t+1, exactly one cycle.
  - Fetch loads JmpTarget at the end of t+1.
  - The word on Instr during t+1 (PC+2 of the jump) is discarded.
  - The word on Instr in t+2 is the first word at the target.
- Back-to-back taken jumps cannot occur: the word after a taken jump is always flushed.
- Flags and RdstData are sampled only in the cycle the jump word is on Instr.

## Structure
- Shared package (decode_pkg): OPW, RW, the four jump opcode constants, the IMM bit index, and the state encoding (S_OP=2'd0, S_IMM=2'd1, S_FLUSH=2'd2). Encoding 2'd3 is unreachable and recovers to S_OP.
- One sub-module, jump_resolver. It is combinational: opcode plus Zf/Nf/Cf in, is_jump and taken out. The FSM and output registers stay in decode_stage.

## Test plan
- Reset mid-immediate: opcode word 16'h6001, then Rst=1 on the next edge → all outputs 0 and state S_OP. Next word 16'h0000 decodes as Valid=1, Opcode=0.
- Two-word instruction: 16'hC021 then 16'hBEEF → Valid 0 in t+1. In t+2: Valid=1, Opcode=5'b11000, Rsrc=0, Rdst=1, Imm=16'hBEEF.
- Taken JZ: Instr=16'hE020, Zf=1, RdstData=32'h0000_0100 → t+1: JmpTaken=1, JmpTarget=32'h100, Valid=1. t+2: Valid=0 (flushed word). t+3: Valid=1 for the target word.
- Untaken JC with Cf=0 → JmpTaken stays 0. No flush; the next word decodes in the following cycle.
- Stall: Stall=1 for 2 cycles during S_IMM → Valid=0 and fields held. The immediate is consumed on the first non-stalled cycle and Valid=1 one cycle after.
- Immediate 16'hF801 (looks like JMP) in S_IMM → JmpTaken stays 0 and Imm=16'hF801.
